// File: rtl/lockable_reg_bank.sv
// -----------------------------------------------------------------------------
// lockable_reg_bank
//
// A small bank of DEPTH registers, WIDTH bits each, with one sticky lock bit
// per register. A register accepts writes until its lock bit is set. After
// that, only a synchronous reset returns the register to an unlocked state.
//
// Writes that cannot land are rejected and recorded as violations. A write is
// rejected when:
//   - the target register is locked,
//   - the target is being locked in the same cycle, or
//   - the address is outside the bank.
// Each violation produces a one-cycle pulse and updates a sticky flag, the
// offending address and a saturating 8-bit count.
//
// Reads are registered. rd_data shows the selected register one cycle after
// rd_addr is presented. If a write to that register is accepted at the same
// edge, rd_data shows the newly written value.
// -----------------------------------------------------------------------------
module lockable_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [DEPTH-1:0] lock_req,
  input  logic             lock_all,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH-1:0] lock_status,
  output logic             viol,
  output logic             viol_sticky,
  output logic [AW-1:0]    viol_addr,
  output logic [7:0]       viol_count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_lock;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_viol;
  logic             r_viol_sticky;
  logic [AW-1:0]    r_viol_addr;
  logic [7:0]       r_viol_count;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic             w_wr_in_range;  // wr_addr names a real register
  logic             w_wr_blocked;   // target locked now or being locked this edge
  logic             w_accept;       // write lands this edge
  logic             w_reject;       // write requested but refused
  logic [WIDTH-1:0] w_rd_word;      // current contents at rd_addr (0 if out of range)
  logic [WIDTH-1:0] w_rd_next;      // value rd_data takes at the next edge
  logic [DEPTH-1:0] w_lock_next;    // lock bits after this edge

  // Address decode for both ports. Comparing against each index avoids
  // out-of-range vector indexing when DEPTH is not a power of two.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_wr_in_range = 1'b0;
    w_wr_blocked  = lock_all;
    w_rd_word     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) begin
        w_wr_in_range = 1'b1;
        w_wr_blocked  = w_wr_blocked | r_lock[i] | lock_req[i];
      end
      if (rd_addr == AW'(i)) begin
        w_rd_word = r_mem[i];
      end
    end
  end

  // Write acceptance. A lock request in the same cycle wins over the write.
  assign w_accept = wr_en & w_wr_in_range & ~w_wr_blocked;
  assign w_reject = wr_en & ~w_accept;

  // Read data as it will look after this edge. An accepted write to the
  // register being read is forwarded into rd_data.
  assign w_rd_next = (w_accept && (rd_addr == wr_addr)) ? wr_data : w_rd_word;

  // Lock bits only accumulate. Nothing but reset clears them.
  assign w_lock_next = r_lock | lock_req | {DEPTH{lock_all}};

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Register storage: reset to RESET_VAL, otherwise take accepted writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage is reset explicitly because every register must
      // read back RESET_VAL after reset. This keeps it in flops rather than
      // letting it map onto a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_accept && (wr_addr == AW'(i))) begin
          // NOTE: state is updated with non-blocking assignments so every
          // flop samples pre-edge values, independent of statement order.
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // Sticky lock bits, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= '0;
    end else begin
      r_lock <= w_lock_next;
    end
  end

  // Registered read port with one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  // Violation tracking: one-cycle pulse, sticky flag, last address and a
  // saturating count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_viol        <= 1'b0;
      r_viol_sticky <= 1'b0;
      r_viol_addr   <= '0;
      r_viol_count  <= '0;
    end else begin
      r_viol <= w_reject;
      if (w_reject) begin
        r_viol_sticky <= 1'b1;
        r_viol_addr   <= wr_addr;
        if (r_viol_count != 8'hFF) begin
          r_viol_count <= r_viol_count + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_data     = r_rd_data;
  assign lock_status = r_lock;
  assign viol        = r_viol;
  assign viol_sticky = r_viol_sticky;
  assign viol_addr   = r_viol_addr;
  assign viol_count  = r_viol_count;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_lockable_reg_bank
//
// Directed bench for lockable_reg_bank using two instances.
//   u_dut_a: WIDTH=8, DEPTH=4, RESET_VAL=0x5A. Nonzero RESET_VAL, so reset
//            values are distinguishable from zero.
//   u_dut_b: WIDTH=8, DEPTH=5, RESET_VAL=0x00. Non-power-of-two depth,
//            exercising out-of-range addresses.
//
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, after the flops have settled.
// -----------------------------------------------------------------------------
module tb_lockable_reg_bank;

  localparam logic [7:0] RV_A = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n;

  // Instance A signals
  logic       a_wr_en;
  logic [1:0] a_wr_addr;
  logic [7:0] a_wr_data;
  logic [3:0] a_lock_req;
  logic       a_lock_all;
  logic [1:0] a_rd_addr;
  logic [7:0] a_rd_data;
  logic [3:0] a_lock_status;
  logic       a_viol;
  logic       a_viol_sticky;
  logic [1:0] a_viol_addr;
  logic [7:0] a_viol_count;

  // Instance B signals
  logic       b_wr_en;
  logic [2:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic [4:0] b_lock_req;
  logic       b_lock_all;
  logic [2:0] b_rd_addr;
  logic [7:0] b_rd_data;
  logic [4:0] b_lock_status;
  logic       b_viol;
  logic       b_viol_sticky;
  logic [2:0] b_viol_addr;
  logic [7:0] b_viol_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lockable_reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV_A)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (a_wr_en),
    .wr_addr     (a_wr_addr),
    .wr_data     (a_wr_data),
    .lock_req    (a_lock_req),
    .lock_all    (a_lock_all),
    .rd_addr     (a_rd_addr),
    .rd_data     (a_rd_data),
    .lock_status (a_lock_status),
    .viol        (a_viol),
    .viol_sticky (a_viol_sticky),
    .viol_addr   (a_viol_addr),
    .viol_count  (a_viol_count)
  );

  lockable_reg_bank #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (b_wr_en),
    .wr_addr     (b_wr_addr),
    .wr_data     (b_wr_data),
    .lock_req    (b_lock_req),
    .lock_all    (b_lock_all),
    .rd_addr     (b_rd_addr),
    .rd_data     (b_rd_data),
    .lock_status (b_lock_status),
    .viol        (b_viol),
    .viol_sticky (b_viol_sticky),
    .viol_addr   (b_viol_addr),
    .viol_count  (b_viol_count)
  );

  // One comparison: count it, and report any difference.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave the bench 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Reset, with a write and lock that must be discarded
    rst_n      = 1'b0;
    a_wr_en    = 1'b1;  a_wr_addr = 2'd3;  a_wr_data = 8'hFF;
    a_lock_req = 4'b1000;  a_lock_all = 1'b0;  a_rd_addr = 2'd3;
    b_wr_en    = 1'b0;  b_wr_addr = 3'd0;  b_wr_data = 8'h00;
    b_lock_req = 5'b0;  b_lock_all = 1'b0;  b_rd_addr = 3'd0;
    tick();
    tick();
    check("rst_rd_data",   a_rd_data,     8'h00);
    check("rst_lock",      a_lock_status, 4'b0000);
    check("rst_viol",      a_viol,        1'b0);
    check("rst_sticky",    a_viol_sticky, 1'b0);
    check("rst_viol_addr", a_viol_addr,   2'd0);
    check("rst_count",     a_viol_count,  8'd0);
    check("rst_b_lock",    b_lock_status, 5'b0);
    check("rst_b_count",   b_viol_count,  8'd0);

    // The write during reset was discarded, so reg 3 still holds RESET_VAL.
    rst_n = 1'b1;  a_wr_en = 1'b0;  a_lock_req = 4'b0;
    tick();
    check("rst_discard_reg3", a_rd_data,     RV_A);
    check("rst_discard_lock", a_lock_status, 4'b0000);

    // ---------------- Write 0xA5 to reg 2 and read it in the same cycle
    a_wr_en = 1'b1;  a_wr_addr = 2'd2;  a_wr_data = 8'hA5;  a_rd_addr = 2'd2;
    tick();
    check("wr2_fwd_rd", a_rd_data, 8'hA5);
    check("wr2_viol",   a_viol,    1'b0);
    a_wr_en = 1'b0;
    tick();
    check("wr2_rd", a_rd_data, 8'hA5);

    // ---------------- Lock reg 1, then write it
    a_lock_req = 4'b0010;
    tick();
    check("lock1_status", a_lock_status, 4'b0010);
    check("lock1_viol",   a_viol,        1'b0);
    a_lock_req = 4'b0;
    a_wr_en = 1'b1;  a_wr_addr = 2'd1;  a_wr_data = 8'h3C;  a_rd_addr = 2'd1;
    tick();
    check("wr1_viol",      a_viol,        1'b1);
    check("wr1_viol_addr", a_viol_addr,   2'd1);
    check("wr1_count",     a_viol_count,  8'd1);
    check("wr1_sticky",    a_viol_sticky, 1'b1);
    check("wr1_rd",        a_rd_data,     RV_A);
    a_wr_en = 1'b0;
    tick();
    check("wr1_viol_drop", a_viol,        1'b0);
    check("wr1_rd_after",  a_rd_data,     RV_A);
    check("wr1_lock_kept", a_lock_status, 4'b0010);

    // ---------------- Same-cycle write and lock on reg 0
    a_wr_en = 1'b1;  a_wr_addr = 2'd0;  a_wr_data = 8'h77;
    a_lock_req = 4'b0001;  a_rd_addr = 2'd0;
    tick();
    check("race0_viol",      a_viol,        1'b1);
    check("race0_count",     a_viol_count,  8'd2);
    check("race0_viol_addr", a_viol_addr,   2'd0);
    check("race0_lock",      a_lock_status, 4'b0011);
    check("race0_rd",        a_rd_data,     RV_A);
    a_wr_en = 1'b0;  a_lock_req = 4'b0;
    tick();
    check("race0_viol_drop", a_viol,    1'b0);
    check("race0_rd_after",  a_rd_data, RV_A);

    // ---------------- Unlocked reg 3 still writable while others are locked
    a_wr_en = 1'b1;  a_wr_addr = 2'd3;  a_wr_data = 8'hC3;  a_rd_addr = 2'd3;
    tick();
    check("wr3_viol",  a_viol,       1'b0);
    check("wr3_rd",    a_rd_data,    8'hC3);
    check("wr3_count", a_viol_count, 8'd2);

    // ---------------- wr_en=0 targeting a locked register: no violation
    a_wr_en = 1'b0;  a_wr_addr = 2'd1;  a_wr_data = 8'hEE;
    tick();
    check("idle_viol",  a_viol,       1'b0);
    check("idle_count", a_viol_count, 8'd2);

    // ---------------- lock_all, then 300 rejected writes
    a_lock_all = 1'b1;
    tick();
    check("lockall_status", a_lock_status, 4'b1111);
    a_lock_all = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a_wr_en   = 1'b1;
      a_wr_addr = 2'(i % 4);
      a_wr_data = 8'(i);
      tick();
      if (i == 251) check("sat_254", a_viol_count, 8'd254);
      if (i == 252) check("sat_255", a_viol_count, 8'd255);
    end
    check("sat_final",     a_viol_count,  8'd255);
    check("sat_sticky",    a_viol_sticky, 1'b1);
    check("sat_viol",      a_viol,        1'b1);
    check("sat_viol_addr", a_viol_addr,   2'd3);
    a_wr_en = 1'b0;
    tick();
    check("sat_hold",      a_viol_count, 8'd255);
    check("sat_viol_drop", a_viol,       1'b0);
    a_rd_addr = 2'd0;  tick();  check("sat_reg0", a_rd_data, RV_A);
    a_rd_addr = 2'd1;  tick();  check("sat_reg1", a_rd_data, RV_A);
    a_rd_addr = 2'd2;  tick();  check("sat_reg2", a_rd_data, 8'hA5);
    a_rd_addr = 2'd3;  tick();  check("sat_reg3", a_rd_data, 8'hC3);

    // Lock bits must survive every non-reset input pattern.
    a_lock_req = 4'b0101;
    tick();
    check("lock_keep_a", a_lock_status, 4'b1111);
    a_lock_req = 4'b0000;  a_wr_en = 1'b1;  a_wr_addr = 2'd2;
    tick();
    check("lock_keep_b", a_lock_status, 4'b1111);
    a_wr_en = 1'b0;
    tick();
    check("lock_keep_c", a_lock_status, 4'b1111);

    // ---------------- Reset mid-operation with locks and viol_count=7
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_count", a_viol_count,  8'd0);
    check("rst2_lock",  a_lock_status, 4'b0000);
    a_wr_en = 1'b1;  a_wr_addr = 2'd0;  a_wr_data = 8'h99;
    tick();
    a_wr_en = 1'b0;  a_lock_req = 4'b0110;
    tick();
    check("pre_lock", a_lock_status, 4'b0110);
    a_lock_req = 4'b0;
    for (int i = 0; i < 7; i++) begin
      a_wr_en = 1'b1;  a_wr_addr = 2'd1;  a_wr_data = 8'h11;
      tick();
    end
    a_wr_en = 1'b0;  a_rd_addr = 2'd0;
    tick();
    check("pre_count",     a_viol_count, 8'd7);
    check("pre_viol_addr", a_viol_addr,  2'd1);
    check("pre_reg0",      a_rd_data,    8'h99);

    // Reset with a concurrent write and lock_all: both are discarded.
    rst_n = 1'b0;  a_wr_en = 1'b1;  a_wr_addr = 2'd2;  a_wr_data = 8'hEE;
    a_lock_all = 1'b1;
    tick();
    check("rst3_lock",      a_lock_status, 4'b0000);
    check("rst3_count",     a_viol_count,  8'd0);
    check("rst3_viol",      a_viol,        1'b0);
    check("rst3_sticky",    a_viol_sticky, 1'b0);
    check("rst3_viol_addr", a_viol_addr,   2'd0);
    check("rst3_rd_data",   a_rd_data,     8'h00);
    rst_n = 1'b1;  a_lock_all = 1'b0;
    a_wr_en = 1'b1;  a_wr_addr = 2'd1;  a_wr_data = 8'h42;  a_rd_addr = 2'd1;
    tick();
    check("post_wr1_rd",   a_rd_data,     8'h42);
    check("post_wr1_viol", a_viol,        1'b0);
    check("post_wr1_lock", a_lock_status, 4'b0000);
    a_wr_en = 1'b0;  a_rd_addr = 2'd0;
    tick();
    check("post_reg0", a_rd_data, RV_A);
    a_rd_addr = 2'd2;
    tick();
    check("post_reg2", a_rd_data, RV_A);

    // ---------------- DEPTH=5 instance: boundary and out-of-range addresses
    b_wr_en = 1'b1;  b_wr_addr = 3'd4;  b_wr_data = 8'h4D;  b_rd_addr = 3'd4;
    tick();
    check("b_wr4_rd",   b_rd_data, 8'h4D);
    check("b_wr4_viol", b_viol,    1'b0);
    b_wr_addr = 3'd6;  b_wr_data = 8'hFF;  b_rd_addr = 3'd6;
    tick();
    check("b_wr6_viol",      b_viol,        1'b1);
    check("b_wr6_viol_addr", b_viol_addr,   3'd6);
    check("b_wr6_count",     b_viol_count,  8'd1);
    check("b_wr6_sticky",    b_viol_sticky, 1'b1);
    check("b_rd6",           b_rd_data,     8'h00);
    check("b_lock_none",     b_lock_status, 5'b0);
    b_wr_en = 1'b0;  b_rd_addr = 3'd5;
    tick();
    check("b_rd5",     b_rd_data, 8'h00);
    check("b_viol_lo", b_viol,    1'b0);
    b_rd_addr = 3'd4;
    tick();
    check("b_rd4_kept", b_rd_data, 8'h4D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lockable_reg_bank.md
LOCKABLE_REG_BANK -- requirements
Module: lockable_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per register (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of registers (2..256).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, meaning the value every register takes at reset.
REQ-004 The block SHALL have derived parameter AW = max(1, clog2(DEPTH)), meaning address width.
REQ-005 The block SHALL have port clk, input, 1, meaning the clock.
REQ-006 The block SHALL have port rst_n, input, 1, meaning the reset: synchronous, active-low.
REQ-007 The block SHALL have port wr_en, input, 1, meaning a write request this cycle.
REQ-008 The block SHALL have port wr_addr, input, AW, meaning the write target index.
REQ-009 The block SHALL have port wr_data, input, WIDTH, meaning the write data.
REQ-010 The block SHALL have port lock_req, input, DEPTH, meaning per-register lock requests.
REQ-011 The block SHALL have port lock_all, input, 1, meaning a request to lock every register.
REQ-012 The block SHALL have port rd_addr, input, AW, meaning the read index.
REQ-013 The block SHALL have port rd_data, output, WIDTH, meaning the registered read data.
REQ-014 The block SHALL have port lock_status, output, DEPTH, meaning the current lock bits.
REQ-015 The block SHALL have port viol, output, 1, meaning a one-cycle pulse for a rejected write.
REQ-016 The block SHALL have port viol_sticky, output, 1, meaning a rejected write has occurred since reset.
REQ-017 The block SHALL have port viol_addr, output, AW, meaning the wr_addr of the most recent rejected write.
REQ-018 The block SHALL have port viol_count, output, 8, meaning a saturating count of rejected writes.

Function
REQ-019 Each register SHALL have one lock bit; a lock bit SHALL be 0 at reset.
REQ-020 Once set, a lock bit SHALL stay 1 until rst_n is low; no input combination SHALL clear it.
REQ-021 Lock bit i SHALL be set at the clock edge where lock_req[i]=1 or lock_all=1.
REQ-022 A write SHALL be accepted when wr_en=1, wr_addr<DEPTH, lock bit [wr_addr]=0, lock_req[wr_addr]=0 and lock_all=0.
REQ-023 An accepted write SHALL update the register at the same edge; it SHALL become visible on rd_data one cycle later when rd_addr selects it.
REQ-024 A lock request SHALL take priority over a write in the same cycle: the write SHALL be rejected and counted as a violation.
REQ-025 A write with wr_en=1 and wr_addr>=DEPTH SHALL be rejected and counted as a violation.
REQ-026 Every rejected write SHALL leave all registers unchanged.
REQ-027 For each rejected write, the block SHALL assert viol for exactly one cycle (the cycle after the request), set viol_sticky, load viol_addr with wr_addr, and increment viol_count.
REQ-028 viol_count SHALL saturate at 255 and hold at 255.
REQ-029 viol_sticky SHALL be cleared only by reset.
REQ-030 The read path SHALL have 1-cycle latency: rd_data(t+1) = reg[rd_addr(t)] as updated at edge t.
REQ-031 When rd_addr>=DEPTH, rd_data SHALL be 0.
REQ-032 lock_status SHALL be registered and SHALL equal the lock bits after each edge.
REQ-033 wr_en=0 SHALL never produce a violation, whatever the lock state.
REQ-034 Writing to an unlocked register SHALL be accepted whether or not other registers are locked.

Reset
REQ-035 While rst_n=0 at a clock edge, all registers SHALL become RESET_VAL.
REQ-036 While rst_n=0 at a clock edge, all lock bits SHALL become 0 and rd_data SHALL become 0.
REQ-037 While rst_n=0 at a clock edge, viol, viol_sticky and viol_count SHALL become 0 and viol_addr SHALL become 0.
REQ-038 Reset SHALL take priority over every concurrent write, lock or read; a write or lock in the reset cycle SHALL be discarded.

Verification
REQ-039 The bench SHALL cover: write 0xA5 to reg 2, then rd_addr=2 -> rd_data=0xA5 one cycle later, viol=0.
REQ-040 The bench SHALL cover: lock_req[1]=1, then write 0x3C to reg 1 -> reg 1 unchanged, viol pulses once, viol_addr=1, viol_count=1, lock_status[1]=1.
REQ-041 The bench SHALL cover: same-cycle wr_en to reg 0 with lock_req[0]=1 -> write rejected, viol pulse, reg 0 still RESET_VAL.
REQ-042 The bench SHALL cover: lock_all, then 300 writes -> viol_count=255, viol_sticky=1, every register unchanged, and no lock bit clearable by any input except reset.
REQ-043 The bench SHALL cover: DEPTH=5 with a write to addr 6 -> rejected, viol_addr=6; rd_addr=6 -> rd_data=0.
REQ-044 The bench SHALL cover: reset mid-operation with locks set and viol_count=7 -> the next cycle shows all lock bits 0, count 0, registers RESET_VAL, and a write to reg 1 is accepted.
